dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: two requester ports (A = pipeline
// MEM stage, B = loader/debug), the shared error flag and the memory port.
// The arbiter uses the slave view; the requesters/memory side uses master.
interface dmem_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [31:0] a_rdata;
    logic        a_ack;
    logic        a_stall;

    logic        b_req;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [31:0] b_rdata;
    logic        b_ack;

    logic        err;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_rdata, a_ack, a_stall,
        input  b_req, b_we, b_addr, b_wdata,
        output b_rdata, b_ack,
        output err,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_rdata, a_ack, a_stall,
        output b_req, b_we, b_addr, b_wdata,
        input  b_rdata, b_ack,
        input  err,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Each access walks IDLE -> ACCESS -> RESP:
// the winning request is latched on entry to ACCESS, the memory is strobed
// for exactly one cycle, and the winner is acked in RESP. Port A normally
// wins; port B wins when A is not requesting or after STARVE_MAX A grants
// were made while B was asking. Misaligned accesses never touch memory and
// complete with err.
module dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int unsigned    CNT_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    state_t           state;
    state_t           state_next;
    port_t            winner;
    logic             grant;
    logic             grant_b;
    logic             op_we;
    logic [31:0]      op_addr;
    logic [31:0]      op_wdata;
    logic [31:0]      rd_data;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;
    logic             misaligned;
    logic             in_access;
    logic             in_resp;

    assign starve_hit = (starve_cnt == CNT_MAX);
    assign misaligned = |op_addr[1:0];
    assign in_access  = (state == ACCESS);
    assign in_resp    = (state == RESP);

    // Next state and grant decision; in RESP only the port not being acked may win.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_b    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    grant      = 1'b1;
                    grant_b    = bus.b_req && (!bus.a_req || starve_hit);
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
                if (winner == PORT_A && bus.b_req) begin
                    grant      = 1'b1;
                    grant_b    = 1'b1;
                    state_next = ACCESS;
                end else if (winner == PORT_B && bus.a_req) begin
                    grant      = 1'b1;
                    grant_b    = 1'b0;
                    state_next = ACCESS;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset drops straight back to IDLE from any state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winning port's operation at the moment of the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winner   <= PORT_A;
            op_we    <= 1'b0;
            op_addr  <= 32'd0;
            op_wdata <= 32'd0;
        end else if (grant) begin
            winner   <= grant_b ? PORT_B : PORT_A;
            op_we    <= grant_b ? bus.b_we : bus.a_we;
            op_addr  <= grant_b ? bus.b_addr : bus.a_addr;
            op_wdata <= grant_b ? bus.b_wdata : bus.a_wdata;
        end
    end

    // Count A grants made while B asks; any B grant gives B a fresh budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (grant_b) begin
                starve_cnt <= '0;
            end else if (bus.b_req && !starve_hit) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // Capture load data at the end of ACCESS; writes and misaligned ops return 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= 32'd0;
        end else if (in_access) begin
            rd_data <= (op_we || misaligned) ? 32'd0 : bus.mem_rdata;
        end
    end

    // Memory strobes, acks, error and gated read data, all decoded from state.
    always_comb begin
        bus.mem_read  = in_access && !op_we && !misaligned;
        bus.mem_write = in_access && op_we && !misaligned;
        bus.mem_addr  = in_access ? op_addr : 32'd0;
        bus.mem_wdata = in_access ? op_wdata : 32'd0;
        bus.a_ack     = in_resp && (winner == PORT_A);
        bus.b_ack     = in_resp && (winner == PORT_B);
        bus.err       = in_resp && misaligned;
        bus.a_rdata   = bus.a_ack ? rd_data : 32'd0;
        bus.b_rdata   = bus.b_ack ? rd_data : 32'd0;
        bus.a_stall   = bus.a_req && !bus.a_ack;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by a randomized run
// scored against a timeline model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        reset;
    int          passed;
    int          total;
    logic [31:0] mem [0:63];
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic        fill_en;
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    dmem_arbiter_if bus();

    dmem_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    // Memory model: bulk random fill, single-word preload, and DUT writes.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
        end
        if (pre_en) mem[pre_idx] = pre_val;
        if (bus.mem_write === 1'b1) begin
            mem[bus.mem_addr[7:2]] = bus.mem_wdata;
            wr_count     = wr_count + 1;
            last_wr_addr = bus.mem_addr;
        end
    end

    task automatic drive_idle;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pre_idx = idx; pre_val = val; pre_en = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic wait_ack(input bit port_b, output int cycles);
        cycles = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((port_b ? bus.b_ack : bus.a_ack) === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int lat;
        logic [31:0] exp;
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h8;
        @(negedge clk);
        total++;
        if ({bus.a_ack, bus.b_ack, bus.err, bus.mem_read, bus.mem_write} !== 5'b0)
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {bus.a_ack, bus.b_ack, bus.err, bus.mem_read, bus.mem_write});
        else passed++;
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.a_rdata, bus.b_rdata} !== 128'd0)
            $display("[TB] FAIL reset_buses: got %h expected 0",
                     {bus.mem_addr, bus.mem_wdata, bus.a_rdata, bus.b_rdata});
        else passed++;
        total++;
        if (bus.a_stall !== 1'b1) $display("[TB] FAIL reset_stall: got %b expected 1", bus.a_stall);
        else passed++;
        exp   = mem[2];
        reset = 0;
        wait_ack(0, lat);
        total++;
        if (lat !== 2) $display("[TB] FAIL first_arb_latency: got %0d expected 2", lat);
        else passed++;
        total++;
        if (bus.a_rdata !== exp) $display("[TB] FAIL first_arb_rdata: got %h expected %h", bus.a_rdata, exp);
        else passed++;
        bus.a_req = 0;
    endtask

    task automatic test_single_read;
        preload(6'd4, 32'hDEADBEEF);
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h10;
        #1;
        total++;
        if ({bus.a_stall, bus.mem_read} !== 2'b10)
            $display("[TB] FAIL read_cycle0: got stall,rd=%b expected 10", {bus.a_stall, bus.mem_read});
        else passed++;
        @(negedge clk);
        total++;
        if ({bus.mem_read, bus.mem_write, bus.a_stall, bus.a_ack} !== 4'b1010 || bus.mem_addr !== 32'h10)
            $display("[TB] FAIL read_cycle1: got rd,wr,stall,ack=%b addr=%h expected 1010 addr=10",
                     {bus.mem_read, bus.mem_write, bus.a_stall, bus.a_ack}, bus.mem_addr);
        else passed++;
        @(negedge clk);
        total++;
        if ({bus.a_ack, bus.a_stall, bus.err} !== 3'b100 || bus.a_rdata !== 32'hDEADBEEF)
            $display("[TB] FAIL read_cycle2: got ack,stall,err=%b rdata=%h expected 100 rdata=deadbeef",
                     {bus.a_ack, bus.a_stall, bus.err}, bus.a_rdata);
        else passed++;
        bus.a_req = 0;
        @(negedge clk);
        total++;
        if (bus.a_ack !== 1'b0 || bus.a_rdata !== 32'd0 || bus.mem_read !== 1'b0)
            $display("[TB] FAIL read_after: got ack=%b rdata=%h rd=%b expected 0 0 0",
                     bus.a_ack, bus.a_rdata, bus.mem_read);
        else passed++;
    endtask

    task automatic test_write_then_read;
        int lat;
        int w0;
        w0 = wr_count;
        @(negedge clk);
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 32'h20; bus.b_wdata = 32'h12345678;
        wait_ack(1, lat);
        total++;
        if (lat !== 2 || bus.b_rdata !== 32'd0)
            $display("[TB] FAIL write_ack: got lat=%0d rdata=%h expected 2 0", lat, bus.b_rdata);
        else passed++;
        bus.b_req = 0; bus.b_we = 0;
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h20;
        wait_ack(0, lat);
        total++;
        if (bus.a_rdata !== 32'h12345678)
            $display("[TB] FAIL write_readback: got %h expected 12345678", bus.a_rdata);
        else passed++;
        bus.a_req = 0;
        total++;
        if (wr_count - w0 !== 1 || last_wr_addr !== 32'h20)
            $display("[TB] FAIL write_pulses: got %0d at %h expected 1 at 20", wr_count - w0, last_wr_addr);
        else passed++;
    endtask

    task automatic test_simultaneous;
        int ta;
        int tb;
        logic [31:0] got_b;
        ta = -1; tb = -1; got_b = 0;
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h30;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h34;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.a_ack === 1'b1 && ta < 0) begin ta = i; bus.a_req = 0; end
            if (bus.b_ack === 1'b1 && tb < 0) begin tb = i; got_b = bus.b_rdata; bus.b_req = 0; end
        end
        total++;
        if (ta !== 2 || tb !== 4)
            $display("[TB] FAIL simultaneous_order: got a=%0d b=%0d expected a=2 b=4", ta, tb);
        else passed++;
        total++;
        if (got_b !== mem[13]) $display("[TB] FAIL simultaneous_bdata: got %h expected %h", got_b, mem[13]);
        else passed++;
    endtask

    // B waits at every IDLE arbitration but withdraws before the acked port's
    // RESP, so only the starvation counter can eventually hand it the grant.
    task automatic test_starvation;
        int lat;
        @(negedge clk);
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h0;
        wait_ack(1, lat);
        bus.b_req = 0;
        total++;
        if (lat !== 2) $display("[TB] FAIL starve_clear: got lat=%0d expected 2", lat);
        else passed++;
        for (int r = 0; r < SMAX; r++) begin
            @(negedge clk);
            bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h40 + 32'(4 * r);
            bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h80;
            @(negedge clk);
            bus.b_req = 0;
            @(negedge clk);
            total++;
            if ({bus.a_ack, bus.b_ack} !== 2'b10)
                $display("[TB] FAIL starve_round%0d: got a,b ack=%b expected 10", r, {bus.a_ack, bus.b_ack});
            else passed++;
            bus.a_req = 0;
        end
        @(negedge clk);
        bus.a_req = 1; bus.a_addr = 32'h60;
        bus.b_req = 1; bus.b_addr = 32'h84;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({bus.a_ack, bus.b_ack} !== 2'b01 || bus.b_rdata !== mem[33])
            $display("[TB] FAIL starve_b_grant: got ack=%b rdata=%h expected 01 %h",
                     {bus.a_ack, bus.b_ack}, bus.b_rdata, mem[33]);
        else passed++;
        bus.b_req = 0;
        @(negedge clk);
        total++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h60)
            $display("[TB] FAIL starve_a_resume: got rd=%b addr=%h expected 1 60", bus.mem_read, bus.mem_addr);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.a_ack !== 1'b1) $display("[TB] FAIL starve_a_ack: got %b expected 1", bus.a_ack);
        else passed++;
        bus.a_req = 0;
    endtask

    // Both ports keep asking with fresh addresses; since the acked port sits
    // out its own RESP decision, grants alternate A, B, A, B every 2 cycles.
    task automatic test_back_to_back;
        int k;
        int bad;
        logic [31:0] exp;
        k = 0; bad = 0;
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h100 >> 2;
        bus.a_addr = 32'h4;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h8C;
        for (int i = 1; i <= 40 && k < 8; i++) begin
            @(negedge clk);
            if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
                exp = (k % 2 == 0) ? mem[bus.a_addr[7:2]] : mem[bus.b_addr[7:2]];
                if (i !== 2 * (k + 1) || bus.a_ack !== (k % 2 == 0) || bus.b_ack !== (k % 2 == 1) ||
                    (bus.a_ack ? bus.a_rdata : bus.b_rdata) !== exp) begin
                    bad++;
                    $display("[TB] FAIL b2b_ack%0d: got cycle=%0d a=%b b=%b data=%h expected cycle=%0d port=%s data=%h",
                             k, i, bus.a_ack, bus.b_ack, bus.a_ack ? bus.a_rdata : bus.b_rdata,
                             2 * (k + 1), (k % 2 == 0) ? "A" : "B", exp);
                end
                if (bus.a_ack === 1'b1) bus.a_addr = bus.a_addr + 32'h10;
                if (bus.b_ack === 1'b1) bus.b_addr = bus.b_addr + 32'h10;
                k++;
            end
        end
        drive_idle();
        total++;
        if (k !== 8 || bad !== 0) $display("[TB] FAIL b2b_summary: got %0d acks %0d bad expected 8 acks 0 bad", k, bad);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_misaligned;
        int w0;
        int lat;
        logic [31:0] m0;
        w0 = wr_count; m0 = mem[4];
        @(negedge clk);
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h13; bus.a_wdata = 32'hCAFEF00D;
        @(negedge clk);
        total++;
        if ({bus.mem_read, bus.mem_write} !== 2'b00)
            $display("[TB] FAIL misaligned_strobe: got rd,wr=%b expected 00", {bus.mem_read, bus.mem_write});
        else passed++;
        @(negedge clk);
        total++;
        if ({bus.a_ack, bus.err} !== 2'b11 || bus.a_rdata !== 32'd0)
            $display("[TB] FAIL misaligned_ack: got ack,err=%b rdata=%h expected 11 0", {bus.a_ack, bus.err}, bus.a_rdata);
        else passed++;
        bus.a_req = 0; bus.a_we = 0;
        total++;
        if (wr_count !== w0 || mem[4] !== m0)
            $display("[TB] FAIL misaligned_mem: got writes=%0d word=%h expected %0d %h", wr_count, mem[4], w0, m0);
        else passed++;
        @(negedge clk);
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h22;
        wait_ack(1, lat);
        total++;
        if (lat !== 2 || bus.err !== 1'b1 || bus.b_rdata !== 32'd0)
            $display("[TB] FAIL misaligned_read: got lat=%0d err=%b rdata=%h expected 2 1 0", lat, bus.err, bus.b_rdata);
        else passed++;
        bus.b_req = 0;
    endtask

    task automatic test_reset_mid_access;
        int w0;
        int lat;
        logic [31:0] m0;
        logic [31:0] exp;
        w0 = wr_count; m0 = mem[16];
        @(negedge clk);
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 32'h40; bus.b_wdata = 32'h55AA55AA;
        @(posedge clk);
        #2;
        total++;
        if (bus.mem_write !== 1'b1) $display("[TB] FAIL midreset_in_access: got wr=%b expected 1", bus.mem_write);
        else passed++;
        reset = 1;
        #1;
        total++;
        if ({bus.a_ack, bus.b_ack, bus.err, bus.mem_read, bus.mem_write} !== 5'b0 ||
            {bus.mem_addr, bus.mem_wdata, bus.a_rdata, bus.b_rdata} !== 128'd0)
            $display("[TB] FAIL midreset_outputs: got flags=%b buses=%h expected 0",
                     {bus.a_ack, bus.b_ack, bus.err, bus.mem_read, bus.mem_write},
                     {bus.mem_addr, bus.mem_wdata, bus.a_rdata, bus.b_rdata});
        else passed++;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (wr_count !== w0 || mem[16] !== m0)
            $display("[TB] FAIL midreset_aborted: got writes=%0d word=%h expected %0d %h", wr_count, mem[16], w0, m0);
        else passed++;
        reset = 0;
        exp = mem[5];
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h14;
        wait_ack(0, lat);
        total++;
        if (lat !== 2 || bus.a_rdata !== exp)
            $display("[TB] FAIL midreset_recover: got lat=%0d rdata=%h expected 2 %h", lat, bus.a_rdata, exp);
        else passed++;
        bus.a_req = 0;
    endtask

    task automatic gen_req(output logic we, output logic [31:0] addr, output logic [31:0] wd);
        we   = 1'($urandom_range(0, 1));
        addr = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
        wd   = $urandom;
    endtask

    // Reference model: an access granted at edge g strobes memory in the cycle
    // after g, is acked in the cycle after g+1 and commits its write at g+1.
    // Arbitration is possible at any edge >= g+2, and at exactly g+2 the port
    // just acked is not a candidate.
    task automatic test_random;
        localparam int N = 600;
        logic [31:0] ref_mem [0:63];
        int   g_edge;
        bit   g_port;
        logic g_we;
        logic g_mis;
        logic [31:0] g_addr;
        logic [31:0] g_wdata;
        logic [31:0] g_rdata;
        int   starve;
        int   bad_mem;
        bit   a_el;
        bit   b_el;
        bit   win_b;
        bit   acc;
        bit   resp;
        logic [5:0]  e_flags;
        logic [95:0] e_bus;
        g_edge = -100; g_port = 0; g_we = 0; g_mis = 0;
        g_addr = 0; g_wdata = 0; g_rdata = 0; starve = 0;
        @(negedge clk);
        reset = 1;
        drive_idle();
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        for (int t = 0; t < N; t++) begin
            @(posedge clk);
            if (t == g_edge + 1 && g_we && !g_mis) ref_mem[g_addr[7:2]] = g_wdata;
            if (t >= g_edge + 2) begin
                a_el = bus.a_req && !(t == g_edge + 2 && g_port == 1'b0);
                b_el = bus.b_req && !(t == g_edge + 2 && g_port == 1'b1);
                if (a_el || b_el) begin
                    win_b = b_el && (!a_el || starve == SMAX);
                    if (win_b) starve = 0;
                    else if (bus.b_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
                    g_edge  = t;
                    g_port  = win_b;
                    g_we    = win_b ? bus.b_we : bus.a_we;
                    g_addr  = win_b ? bus.b_addr : bus.a_addr;
                    g_wdata = win_b ? bus.b_wdata : bus.a_wdata;
                    g_mis   = (g_addr[1:0] != 2'b00);
                    g_rdata = (g_we || g_mis) ? 32'd0 : ref_mem[g_addr[7:2]];
                end
            end
            acc  = (t == g_edge);
            resp = (t == g_edge + 1);
            e_flags = {acc && !g_we && !g_mis, acc && g_we && !g_mis,
                       resp && !g_port, resp && g_port, resp && g_mis,
                       bus.a_req && !(resp && !g_port)};
            e_bus = {acc ? g_addr : 32'd0,
                     (resp && !g_port) ? g_rdata : 32'd0,
                     (resp && g_port) ? g_rdata : 32'd0};
            @(negedge clk);
            total++;
            if ({bus.mem_read, bus.mem_write, bus.a_ack, bus.b_ack, bus.err, bus.a_stall} !== e_flags)
                $display("[TB] FAIL rand_flags@%0d: got rd,wr,aack,back,err,stall=%b expected %b", t,
                         {bus.mem_read, bus.mem_write, bus.a_ack, bus.b_ack, bus.err, bus.a_stall}, e_flags);
            else passed++;
            total++;
            if ({bus.mem_addr, bus.a_rdata, bus.b_rdata} !== e_bus)
                $display("[TB] FAIL rand_data@%0d: got addr,ardata,brdata=%h expected %h", t,
                         {bus.mem_addr, bus.a_rdata, bus.b_rdata}, e_bus);
            else passed++;
            if (t >= N - 8) begin
                drive_idle();
            end else begin
                if (bus.a_req && bus.a_ack === 1'b1) bus.a_req = ($urandom_range(0, 2) == 0);
                else if (bus.a_req && $urandom_range(0, 19) == 0) bus.a_req = 0;
                else if (!bus.a_req) bus.a_req = ($urandom_range(0, 4) < 2);
                if (bus.a_req && (bus.a_ack === 1'b1 || !bus.a_stall)) gen_req(bus.a_we, bus.a_addr, bus.a_wdata);
                if (bus.b_req && bus.b_ack === 1'b1) bus.b_req = ($urandom_range(0, 2) == 0);
                else if (bus.b_req && $urandom_range(0, 19) == 0) bus.b_req = 0;
                else if (!bus.b_req) bus.b_req = ($urandom_range(0, 4) < 2);
                if (bus.b_req && bus.b_ack === 1'b1) gen_req(bus.b_we, bus.b_addr, bus.b_wdata);
                else if (bus.b_req && $urandom_range(0, 3) == 0) gen_req(bus.b_we, bus.b_addr, bus.b_wdata);
            end
        end
        bad_mem = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad_mem++;
        total++;
        if (bad_mem !== 0) $display("[TB] FAIL rand_memory: got %0d differing words expected 0", bad_mem);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        pre_en = 1'b0;
        pre_idx = 6'd0;
        pre_val = 32'd0;
        drive_idle();
        fill_en = 1'b1;
        @(posedge clk);
        #1 fill_en = 1'b0;
        $display("[TB] starting dmem_arbiter bench");
        test_reset();
        test_single_read();
        test_write_then_read();
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
